// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file with byte strobes, flat register export and per-register write pulses.
// Define AXIL_REGFILE_DECERR_EN to answer out-of-range accesses with DECERR instead of SLVERR.
module axil_slave_regfile #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic [2:0]               s_axil_awprot,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

`ifdef AXIL_REGFILE_DECERR_EN
  localparam logic [1:0] RESP_ERR = 2'b11;
`else
  localparam logic [1:0] RESP_ERR = 2'b10;
`endif
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         IDX_W     = ADDR_WIDTH - 2;

  logic                alive_q, alive_d;
  logic                aw_held_q, aw_held_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
  logic                w_held_q, w_held_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic             wr_in_range, rd_in_range;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [31:0]      wr_data, rd_word;
  logic [3:0]       wr_strb;
  logic             unused_ok;

  assign s_axil_awready = alive_q & ~aw_held_q & ~bvalid_q;
  assign s_axil_wready  = alive_q & ~w_held_q & ~bvalid_q;
  assign s_axil_arready = alive_q & ~rvalid_q;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // The write commits on the edge that completes the pair, using whichever half is still live on the bus.
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_idx  = aw_hs ? s_axil_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data = w_hs ? s_axil_wdata : wdata_q;
  assign wr_strb = w_hs ? s_axil_wstrb : wstrb_q;
  assign rd_idx  = s_axil_araddr[ADDR_WIDTH-1:2];

  assign wr_in_range = 32'(wr_idx) < $unsigned(NUM_REGS);
  assign rd_in_range = 32'(rd_idx) < $unsigned(NUM_REGS);

  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    alive_d    = 1'b1;
    aw_held_d  = (aw_held_q | aw_hs) & ~commit;
    aw_idx_d   = aw_hs ? s_axil_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
    w_held_d   = (w_held_q | w_hs) & ~commit;
    wdata_d    = w_hs ? s_axil_wdata : wdata_q;
    wstrb_d    = w_hs ? s_axil_wstrb : wstrb_q;
    bvalid_d   = bvalid_q & ~s_axil_bready;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q & ~s_axil_rready;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_in_range ? RESP_OKAY : RESP_ERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_in_range && wr_idx == IDX_W'(i)) begin
          wr_pulse_d[i] = 1'b1;
          for (int k = 0; k < 4; k++) begin
            if (wr_strb[k]) regs_d[i][8*k +: 8] = wr_data[8*k +: 8];
          end
        end
      end
    end

    // Reads sample regs_q, so a same-edge write to the same register is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? rd_word : 32'h0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_ERR;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      alive_q    <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      alive_q    <= alive_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign regs_o[32*g +: 32] = regs_q[g];
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed self-checking bench for axil_slave_regfile; expected error code follows AXIL_REGFILE_DECERR_EN.
module tb_axil_slave_regfile;
  localparam int ADDR_WIDTH = 12;
  localparam int NUM_REGS   = 16;
`ifdef AXIL_REGFILE_DECERR_EN
  localparam logic [1:0] ERR = 2'b11;
`else
  localparam logic [1:0] ERR = 2'b10;
`endif

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic [ADDR_WIDTH-1:0]   s_axil_awaddr = '0;
  logic [2:0]              s_axil_awprot = '0;
  logic                    s_axil_awvalid = 1'b0;
  logic                    s_axil_awready;
  logic [31:0]             s_axil_wdata = '0;
  logic [3:0]              s_axil_wstrb = '0;
  logic                    s_axil_wvalid = 1'b0;
  logic                    s_axil_wready;
  logic [1:0]              s_axil_bresp;
  logic                    s_axil_bvalid;
  logic                    s_axil_bready = 1'b0;
  logic [ADDR_WIDTH-1:0]   s_axil_araddr = '0;
  logic [2:0]              s_axil_arprot = '0;
  logic                    s_axil_arvalid = 1'b0;
  logic                    s_axil_arready;
  logic [31:0]             s_axil_rdata;
  logic [1:0]              s_axil_rresp;
  logic                    s_axil_rvalid;
  logic                    s_axil_rready = 1'b0;
  logic [NUM_REGS*32-1:0]  regs_o;
  logic [NUM_REGS-1:0]     wr_pulse_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [NUM_REGS*32-1:0] model = '0;

  axil_slave_regfile #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .RESET_VALUE(32'h0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 aclk = ~aclk;

  // Full write through both channels; ok drops if a handshake or the response never arrives.
  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic ok);
    bit aw_done, w_done, aw_fire, w_fire;
    resp = 2'bxx;
    aw_done = 0;
    w_done = 0;
    s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
    s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
    s_axil_bready = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_fire = s_axil_awvalid && s_axil_awready;
      w_fire  = s_axil_wvalid && s_axil_wready;
      @(negedge aclk);
      if (aw_fire) begin aw_done = 1; s_axil_awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1;  s_axil_wvalid = 1'b0; end
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    ok = 1'b0;
    if (aw_done && w_done) begin
      for (int i = 0; i < 20 && !ok; i++) begin
        if (s_axil_bvalid) begin resp = s_axil_bresp; ok = 1'b1; end
        @(negedge aclk);
      end
    end
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output logic ok);
    bit ar_done, ar_fire;
    data = 'x;
    resp = 2'bxx;
    ar_done = 0;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    for (int i = 0; i < 20 && !ar_done; i++) begin
      ar_fire = s_axil_arvalid && s_axil_arready;
      @(negedge aclk);
      if (ar_fire) begin ar_done = 1; s_axil_arvalid = 1'b0; end
    end
    s_axil_arvalid = 1'b0;
    ok = 1'b0;
    if (ar_done) begin
      for (int i = 0; i < 20 && !ok; i++) begin
        if (s_axil_rvalid) begin data = s_axil_rdata; resp = s_axil_rresp; ok = 1'b1; end
        @(negedge aclk);
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_axil_bready = 1'b1;
    s_axil_rready = 1'b1;
    repeat (5) @(negedge aclk);
    n_cmp++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin n_err++;
      $display("[TB] FAIL reset_readies: got %b want 000", {s_axil_awready, s_axil_wready, s_axil_arready}); end
    n_cmp++; if ({s_axil_bvalid, s_axil_rvalid} !== 2'b00) begin n_err++;
      $display("[TB] FAIL reset_valids: got %b want 00", {s_axil_bvalid, s_axil_rvalid}); end
    n_cmp++; if (regs_o !== model) begin n_err++;
      $display("[TB] FAIL reset_regs: got %h want %h", regs_o, model); end
    n_cmp++; if ({wr_pulse_o, s_axil_rdata, s_axil_bresp, s_axil_rresp} !== 52'h0) begin n_err++;
      $display("[TB] FAIL reset_outputs: got pulse %h rdata %h bresp %b rresp %b want all zero",
               wr_pulse_o, s_axil_rdata, s_axil_bresp, s_axil_rresp); end
    aresetn = 1'b1;
    #1;
    n_cmp++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin n_err++;
      $display("[TB] FAIL release_readies: got %b want 000", {s_axil_awready, s_axil_wready, s_axil_arready}); end
    @(negedge aclk);
    n_cmp++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin n_err++;
      $display("[TB] FAIL alive_readies: got %b want 111", {s_axil_awready, s_axil_wready, s_axil_arready}); end
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] d; logic [1:0] r; logic ok;
    s_axil_awaddr = 12'h008; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hDEADBEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    s_axil_bready = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    model[64 +: 32] = 32'hDEADBEEF;
    n_cmp++; if ({s_axil_bvalid, s_axil_bresp} !== 3'b100) begin n_err++;
      $display("[TB] FAIL same_bvalid_bresp: got %b want 100", {s_axil_bvalid, s_axil_bresp}); end
    n_cmp++; if (regs_o[95:64] !== 32'hDEADBEEF) begin n_err++;
      $display("[TB] FAIL same_reg2: got %h want deadbeef", regs_o[95:64]); end
    n_cmp++; if (wr_pulse_o !== 16'h0004) begin n_err++;
      $display("[TB] FAIL same_pulse: got %h want 0004", wr_pulse_o); end
    @(negedge aclk);
    n_cmp++; if ({s_axil_bvalid, wr_pulse_o} !== 17'h0) begin n_err++;
      $display("[TB] FAIL same_after: got bvalid %b pulse %h want 0/0000", s_axil_bvalid, wr_pulse_o); end
    axi_read(12'h008, d, r, ok);
    n_cmp++; if ({ok, r, d} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin n_err++;
      $display("[TB] FAIL same_readback: got ok %b resp %b data %h want 1/00/deadbeef", ok, r, d); end
  endtask

  task automatic test_decoupled_strobe();
    s_axil_wdata = 32'h11223344; s_axil_wstrb = 4'b0101; s_axil_wvalid = 1'b1;
    s_axil_bready = 1'b1;
    @(negedge aclk);
    s_axil_wvalid = 1'b0;
    n_cmp++; if ({s_axil_wready, s_axil_awready, s_axil_bvalid} !== 3'b010) begin n_err++;
      $display("[TB] FAIL dec_held: got wready/awready/bvalid %b want 010",
               {s_axil_wready, s_axil_awready, s_axil_bvalid}); end
    repeat (2) @(negedge aclk);
    n_cmp++; if ({s_axil_wready, s_axil_bvalid, regs_o[127:96]} !== {2'b00, 32'h0}) begin n_err++;
      $display("[TB] FAIL dec_wait: got wready %b bvalid %b reg3 %h want 0/0/00000000",
               s_axil_wready, s_axil_bvalid, regs_o[127:96]); end
    s_axil_awaddr = 12'h00C; s_axil_awvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0;
    model[96 +: 32] = 32'h00220044;
    n_cmp++; if ({s_axil_bvalid, s_axil_bresp} !== 3'b100) begin n_err++;
      $display("[TB] FAIL dec_bvalid: got %b want 100", {s_axil_bvalid, s_axil_bresp}); end
    n_cmp++; if (regs_o !== model) begin n_err++;
      $display("[TB] FAIL dec_regs: got %h want %h", regs_o, model); end
    n_cmp++; if (wr_pulse_o !== 16'h0008) begin n_err++;
      $display("[TB] FAIL dec_pulse: got %h want 0008", wr_pulse_o); end
    @(negedge aclk);
  endtask

  task automatic test_backpressure();
    logic [1:0] r; logic ok;
    s_axil_bready = 1'b0;
    s_axil_awaddr = 12'h014; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h55AA55AA; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    model[160 +: 32] = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready} !== 5'b10000) begin n_err++;
        $display("[TB] FAIL bp_hold_%0d: got bvalid/bresp/awready/wready %b want 10000", i,
                 {s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready}); end
      @(negedge aclk);
    end
    s_axil_bready = 1'b1;
    @(negedge aclk);
    n_cmp++; if ({s_axil_bvalid, s_axil_awready, s_axil_wready} !== 3'b011) begin n_err++;
      $display("[TB] FAIL bp_release: got %b want 011", {s_axil_bvalid, s_axil_awready, s_axil_wready}); end
    axi_write(12'h018, 32'h00000066, 4'hF, r, ok);
    model[192 +: 32] = 32'h00000066;
    n_cmp++; if ({ok, r} !== 3'b100) begin n_err++;
      $display("[TB] FAIL bp_second: got ok %b resp %b want 1/00", ok, r); end
    n_cmp++; if (regs_o !== model) begin n_err++;
      $display("[TB] FAIL bp_regs: got %h want %h", regs_o, model); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; logic ok;
    s_axil_bready = 1'b1;
    s_axil_awaddr = 12'h040; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hFFFFFFFF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n_cmp++; if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, ERR}) begin n_err++;
      $display("[TB] FAIL oor_bresp: got %b want %b", {s_axil_bvalid, s_axil_bresp}, {1'b1, ERR}); end
    n_cmp++; if (wr_pulse_o !== 16'h0) begin n_err++;
      $display("[TB] FAIL oor_pulse: got %h want 0000", wr_pulse_o); end
    n_cmp++; if (regs_o !== model) begin n_err++;
      $display("[TB] FAIL oor_regs: got %h want %h", regs_o, model); end
    @(negedge aclk);
    axi_read(12'h040, d, r, ok);
    n_cmp++; if ({ok, r, d} !== {1'b1, ERR, 32'h0}) begin n_err++;
      $display("[TB] FAIL oor_read: got ok %b resp %b data %h want 1/%b/00000000", ok, r, d, ERR); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_write(12'h004, 32'h0000000A, 4'hF, r, ok);
    model[32 +: 32] = 32'h0000000A;
    n_cmp++; if ({ok, r, regs_o[63:32]} !== {3'b100, 32'hA}) begin n_err++;
      $display("[TB] FAIL col_setup: got ok %b resp %b reg1 %h want 1/00/0000000a", ok, r, regs_o[63:32]); end
    s_axil_awaddr = 12'h004; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h0000000B; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    s_axil_araddr = 12'h004; s_axil_arvalid = 1'b1;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    model[32 +: 32] = 32'h0000000B;
    n_cmp++; if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {3'b100, 32'hA}) begin n_err++;
      $display("[TB] FAIL col_pre_value: got rvalid %b rresp %b rdata %h want 1/00/0000000a",
               s_axil_rvalid, s_axil_rresp, s_axil_rdata); end
    n_cmp++; if ({s_axil_bvalid, regs_o[63:32]} !== {1'b1, 32'hB}) begin n_err++;
      $display("[TB] FAIL col_write: got bvalid %b reg1 %h want 1/0000000b", s_axil_bvalid, regs_o[63:32]); end
    @(negedge aclk);
    axi_read(12'h004, d, r, ok);
    n_cmp++; if ({ok, r, d} !== {3'b100, 32'hB}) begin n_err++;
      $display("[TB] FAIL col_readback: got ok %b resp %b data %h want 1/00/0000000b", ok, r, d); end
  endtask

  task automatic test_back_to_back();
    int cnt, bad;
    cnt = 0;
    bad = 0;
    s_axil_araddr = 12'h008; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    repeat (8) begin
      @(negedge aclk);
      if (s_axil_rvalid) begin
        cnt++;
        if (s_axil_rdata !== 32'hDEADBEEF) bad++;
      end
    end
    s_axil_arvalid = 1'b0;
    @(negedge aclk);
    n_cmp++; if (cnt !== 4) begin n_err++;
      $display("[TB] FAIL b2b_rate: got %0d reads in 8 cycles want 4", cnt); end
    n_cmp++; if (bad !== 0) begin n_err++;
      $display("[TB] FAIL b2b_data: got %0d bad beats want 0", bad); end
  endtask

  task automatic test_reset_mid();
    s_axil_bready = 1'b1;
    s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(negedge aclk);
    s_axil_wvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    model = '0;
    n_cmp++; if ({s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_wready} !== 4'b0000) begin n_err++;
      $display("[TB] FAIL mid_reset_state: got %b want 0000",
               {s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_wready}); end
    n_cmp++; if (regs_o !== model) begin n_err++;
      $display("[TB] FAIL mid_reset_regs: got %h want %h", regs_o, model); end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    s_axil_awaddr = 12'h008; s_axil_awvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0;
    n_cmp++; if ({s_axil_bvalid, regs_o[95:64]} !== 33'h0) begin n_err++;
      $display("[TB] FAIL mid_stale_w: got bvalid %b reg2 %h want 0/00000000", s_axil_bvalid, regs_o[95:64]); end
    s_axil_wdata = 32'h0000CAFE; s_axil_wvalid = 1'b1;
    @(negedge aclk);
    s_axil_wvalid = 1'b0;
    n_cmp++; if ({s_axil_bvalid, regs_o[95:64]} !== {1'b1, 32'h0000CAFE}) begin n_err++;
      $display("[TB] FAIL mid_resume: got bvalid %b reg2 %h want 1/0000cafe", s_axil_bvalid, regs_o[95:64]); end
    @(negedge aclk);
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_decoupled_strobe();
    test_backpressure();
    test_out_of_range();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
